mlp_feature_framer: RTL

//  Upstream front-end for the combinational printed-MLP classifiers (redwine, 11 features x 4b).

---
 rtl/mlp_pkg.sv | 17 +
 rtl/feature_quantizer.sv | 30 +++
 rtl/mlp_feature_framer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mlp_pkg.sv
// Shared defaults and types for the printed-MLP feature framer.
package mlp_pkg;

    localparam int N_FEAT = 11;
    localparam int IN_W   = 8;
    localparam int FEAT_W = 4;
    localparam int CLS_W  = 3;

    typedef enum logic [1:0] {
        COLLECT,
        SETTLE,
        OUT
    } framer_state_t;

    typedef logic [FEAT_W-1:0] feat_t;

endpackage

// File: rtl/feature_quantizer.sv
// Combinational IN_W -> FEAT_W sample quantizer: truncation by default,
// round half-up with saturation when MLP_FRAMER_ROUND_EN is defined.
module feature_quantizer #(
    parameter int IN_W   = 8,
    parameter int FEAT_W = 4
) (
    input  logic [IN_W-1:0]   x,
    output logic [FEAT_W-1:0] q
);

    localparam int SH = IN_W - FEAT_W;

`ifdef MLP_FRAMER_ROUND_EN
    localparam logic [IN_W:0] HALF = (IN_W+1)'(1) << (SH - 1);

    logic [IN_W:0] sum;
    logic          unused_lsb;

    // The extra carry bit set means the rounded value overflowed FEAT_W bits.
    assign sum        = {1'b0, x} + HALF;
    assign q          = sum[IN_W] ? {FEAT_W{1'b1}} : sum[IN_W-1 -: FEAT_W];
    assign unused_lsb = ^sum[SH-1:0];
`else
    logic unused_lsb;

    assign q          = x[IN_W-1 -: FEAT_W];
    assign unused_lsb = ^x[SH-1:0];
`endif

endmodule

// File: rtl/mlp_feature_framer.sv
// Frames quantized feature samples into the flat classifier input vector and
// returns the settled class index over valid/ready. Option macro: MLP_FRAMER_ROUND_EN.
module mlp_feature_framer #(
    parameter int N_FEAT = mlp_pkg::N_FEAT,
    parameter int IN_W   = mlp_pkg::IN_W,
    parameter int FEAT_W = mlp_pkg::FEAT_W,
    parameter int CLS_W  = mlp_pkg::CLS_W,
    parameter int SETTLE = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [IN_W-1:0]          s_data,
    input  logic                     s_last,
    output logic [N_FEAT*FEAT_W-1:0] feat_vec,
    input  logic [CLS_W-1:0]         cls_in,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [CLS_W-1:0]         m_class,
    output logic                     err_frame,
    output logic [15:0]              frame_cnt
);

    import mlp_pkg::*;

    localparam int IDX_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    framer_state_t                    state, state_next;
    logic [IDX_W-1:0]                 idx;
    logic [CNT_W-1:0]                 settle_cnt;
    logic [N_FEAT-1:0][FEAT_W-1:0]    shadow;
    logic [N_FEAT-1:0][FEAT_W-1:0]    shadow_wr;
    logic [N_FEAT*FEAT_W-1:0]         feat_vec_q;
    logic                             m_valid_q;
    logic [CLS_W-1:0]                 m_class_q;
    logic                             err_frame_q;
    logic [15:0]                      frame_cnt_q;
    logic [FEAT_W-1:0]                q_feat;

    logic accept, last_slot, commit, frame_err;
    logic in_settle, settle_done, deliver;

    feature_quantizer #(
        .IN_W   (IN_W),
        .FEAT_W (FEAT_W)
    ) u_quant (
        .x (s_data),
        .q (q_feat)
    );

    // The module parameter SETTLE hides the package literal, so the state is named explicitly.
    assign in_settle   = (state == mlp_pkg::SETTLE);
    assign accept      = s_valid && (state == COLLECT);
    assign last_slot   = (idx == IDX_W'(N_FEAT - 1));
    assign commit      = accept && last_slot && s_last;
    assign frame_err   = accept && (s_last != last_slot);
    assign settle_done = in_settle && (settle_cnt == CNT_W'(SETTLE - 1));
    assign deliver     = m_valid_q && m_ready;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        shadow_wr      = shadow;
        shadow_wr[idx] = q_feat;
    end

    always_comb begin
        state_next = state;
        case (state)
            COLLECT:         if (commit)      state_next = mlp_pkg::SETTLE;
            mlp_pkg::SETTLE: if (settle_done) state_next = OUT;
            OUT:             if (deliver)     state_next = COLLECT;
            default:                          state_next = COLLECT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= COLLECT;
        else     state <= state_next;
    end

    // NOTE: shadow is a handful of flops rather than a RAM, so it is cleared with everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx         <= '0;
            settle_cnt  <= '0;
            shadow      <= '0;
            feat_vec_q  <= '0;
            m_valid_q   <= 1'b0;
            m_class_q   <= '0;
            err_frame_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            err_frame_q <= frame_err;
            if (accept) begin
                idx <= (commit || frame_err) ? '0 : idx + IDX_W'(1);
                if (!frame_err) shadow <= shadow_wr;
            end
            // The slot being written this edge is merged straight into the committed vector.
            if (commit) begin
                feat_vec_q <= shadow_wr;
                settle_cnt <= '0;
            end else if (in_settle) begin
                settle_cnt <= settle_cnt + CNT_W'(1);
            end
            if (settle_done) begin
                m_class_q <= cls_in;
                m_valid_q <= 1'b1;
            end
            if (deliver) begin
                m_valid_q   <= 1'b0;
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    assign s_ready   = (state == COLLECT);
    assign feat_vec  = feat_vec_q;
    assign m_valid   = m_valid_q;
    assign m_class   = m_class_q;
    assign err_frame = err_frame_q;
    assign frame_cnt = frame_cnt_q;

endmodule
